// File: rtl/ttseq_pkg.sv
// Shared widths and state encoding for the truth-table sequencer.
package ttseq_pkg;

  localparam int unsigned N_IN  = 3;  // datapath inputs a, b, c
  localparam int unsigned TBL_W = 8;  // 2**N_IN truth-table entries
  localparam int unsigned CNT_W = 4;  // width of the ones count (0..8)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ttseq_popcount.sv
// Combinational population count of a captured truth table.
module ttseq_popcount
  import ttseq_pkg::*;
(
  input  logic [TBL_W-1:0] bits_i,
  output logic [CNT_W-1:0] count_c
);

  // Sum the set bits of the table.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < TBL_W; i++) begin
      count_c = count_c + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks abc through 0..7, holding each combination SETTLE cycles, and
// captures the external datapath output f_in into an 8-bit truth table.
// Optional feature macro: TTSEQ_ONES_COUNT_EN (registered popcount on ones_cnt).
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int unsigned SETTLE = 1  // legal range 1..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f_in,
  output logic [N_IN-1:0]  abc,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_q,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam int unsigned SET_W = 2;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(TBL_W - 1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [TBL_W-1:0] tbl_q, tbl_d;
  logic [N_IN-1:0]  abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tbl_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          tbl_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Abort beats a capture due in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == SET_LAST) begin
          tbl_d[idx_q] = f_in;
          cnt_d        = '0;
          // Index parks at 7; it only wraps on the next accepted start.
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    abc_d  = (state_d == RUN) ? idx_d : '0;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign abc     = abc_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_q = tbl_q;

`ifdef TTSEQ_ONES_COUNT_EN
  logic [CNT_W-1:0] pop_c;
  logic [CNT_W-1:0] ones_q;

  ttseq_popcount u_popcount (
    .bits_i  (tbl_d),
    .count_c (pop_c)
  );

  // Count tracks the next table so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
    end else begin
      ones_q <= pop_c;
    end
  end

  assign ones_cnt = ones_q;
`else
  assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: SETTLE=1 and SETTLE=3 instances.
module tb_truth_table_sequencer;

  localparam logic [7:0] TBL_FULL = 8'hCD;  // f=(~a|b)&(b|~c) over abc=0..7
  localparam logic [7:0] TBL_AB4  = 8'h0D;  // entries 0..3 only
`ifdef TTSEQ_ONES_COUNT_EN
  localparam logic [3:0] ONES_FULL = 4'd5;
`else
  localparam logic [3:0] ONES_FULL = 4'd0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start1, abort1, start3, abort3;
  logic       f1, f3;
  logic [2:0] abc1, abc3;
  logic       busy1, busy3, done1, done3;
  logic [7:0] tbl1, tbl3;
  logic [3:0] ones1, ones3;

  int n_checks = 0;
  int n_err    = 0;

  // External datapath model for each instance.
  assign f1 = (~abc1[2] | abc1[1]) & (abc1[1] | ~abc1[0]);
  assign f3 = (~abc3[2] | abc3[1]) & (abc3[1] | ~abc3[0]);

  truth_table_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f1),
    .abc(abc1), .busy(busy1), .done(done1), .table_q(tbl1), .ones_cnt(ones1)
  );

  truth_table_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f_in(f3),
    .abc(abc3), .busy(busy3), .done(done3), .table_q(tbl3), .ones_cnt(ones3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start3 = 1'b0; abort3 = 1'b0;
    #1;
    check("rst_abc",  32'(abc1),  32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_tbl",  32'(tbl1),  32'h0);
    check("rst_ones", 32'(ones1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // SETTLE=1 full run: abc 0..7 one cycle each, done in cycle 9.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("s1_abc%0d", k),  32'(abc1),  32'(k));
      check($sformatf("s1_busy%0d", k), 32'(busy1), 32'h1);
      check($sformatf("s1_done%0d", k), 32'(done1), 32'h0);
      tick();
    end
    check("s1_done",      32'(done1), 32'h1);
    check("s1_busy_done", 32'(busy1), 32'h0);
    check("s1_abc_done",  32'(abc1),  32'h0);
    check("s1_tbl",       32'(tbl1),  32'(TBL_FULL));
    check("s1_ones",      32'(ones1), 32'(ONES_FULL));
    tick();
    check("s1_done_pulse", 32'(done1), 32'h0);
    check("s1_tbl_hold",   32'(tbl1),  32'(TBL_FULL));
    check("s1_ones_hold",  32'(ones1), 32'(ONES_FULL));

    // start and abort together in IDLE: abort wins, table untouched.
    start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    check("sa_busy", 32'(busy1), 32'h0);
    check("sa_tbl",  32'(tbl1),  32'(TBL_FULL));
    tick();
    check("sa_busy2", 32'(busy1), 32'h0);

    // SETTLE=3 full run: each abc held 3 cycles, done in cycle 25.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        check($sformatf("s3_abc%0d_%0d", k, s),  32'(abc3),  32'(k));
        check($sformatf("s3_busy%0d_%0d", k, s), 32'(busy3), 32'h1);
        check($sformatf("s3_done%0d_%0d", k, s), 32'(done3), 32'h0);
        tick();
      end
    end
    check("s3_done", 32'(done3), 32'h1);
    check("s3_tbl",  32'(tbl3),  32'(TBL_FULL));
    check("s3_ones", 32'(ones3), 32'(ONES_FULL));
    tick();
    check("s3_done_pulse", 32'(done3), 32'h0);

    // Abort while abc==4: entries 0..3 kept, no done.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick(); tick();
    check("ab_abc4", 32'(abc1), 32'h4);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("ab_busy", 32'(busy1), 32'h0);
    check("ab_abc",  32'(abc1),  32'h0);
    check("ab_done", 32'(done1), 32'h0);
    check("ab_tbl",  32'(tbl1),  32'(TBL_AB4));
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done1) ndone++;
      tick();
    end
    check("ab_no_done", 32'(ndone), 32'h0);
    check("ab_tbl_hold", 32'(tbl1), 32'(TBL_AB4));

    // start held high through RUN and DONE: one done, restart only from IDLE.
    start1 = 1'b1;
    tick();
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("hd_abc%0d", k), 32'(abc1), 32'(k));
      if (done1) ndone++;
      tick();
    end
    if (done1) ndone++;
    check("hd_done", 32'(done1), 32'h1);
    check("hd_tbl",  32'(tbl1),  32'(TBL_FULL));
    tick();
    if (done1) ndone++;
    check("hd_one_done",  32'(ndone), 32'h1);
    check("hd_idle_busy", 32'(busy1), 32'h0);
    tick();
    check("hd_rerun_busy", 32'(busy1), 32'h1);
    check("hd_rerun_abc",  32'(abc1),  32'h0);
    check("hd_rerun_tbl",  32'(tbl1),  32'h0);
    start1 = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("rs_abc5", 32'(abc1), 32'h5);

    // Reset mid-run: outputs clear at once, no done afterwards.
    rst_n = 1'b0;
    #1;
    check("rs_abc",  32'(abc1),  32'h0);
    check("rs_busy", 32'(busy1), 32'h0);
    check("rs_done", 32'(done1), 32'h0);
    check("rs_tbl",  32'(tbl1),  32'h0);
    check("rs_ones", 32'(ones1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done1 || busy1) ndone++;
    end
    check("rs_quiet", 32'(ndone), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
